// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-stage load/store unit.
//   - funct3 width codes used by loads and stores
//   - lsu_state_t : FSM states of mem_access
//   - lsu_size_t  : access size after funct3 decode
//   - f3_size()   : funct3 -> access size (unused codes fall back to word)
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Codes 011, 110 and 111 have no defined width and behave as a word.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      F3_W:        f3_size = SZ_W;
      default:     f3_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
// Ports:
//   i_funct3     in  3  : width code
//   i_off        in  2  : byte offset within the word (addr[1:0])
//   i_store_data in  32 : raw store data
//   i_rdata      in  32 : raw read word from the bus
//   o_wdata      out 32 : store data replicated onto every candidate lane
//   o_wstrb      out 4  : byte enables for the store
//   o_misaligned out 1  : access crosses its natural alignment
//   o_load_data  out 32 : selected lane, sign- or zero-extended
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_misaligned,
  output logic [31:0] o_load_data
);

  lsu_size_t   w_size;
  logic [31:0] w_lane;
  logic        w_unsigned;

  assign w_size     = f3_size(i_funct3);
  // funct3[2] distinguishes BU/HU from B/H.
  assign w_unsigned = i_funct3[2];
  assign w_lane     = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_wdata      = i_store_data;
    o_wstrb      = 4'b1111;
    o_misaligned = 1'b0;
    o_load_data  = w_lane;
    case (w_size)
      SZ_B: begin
        o_wdata      = {4{i_store_data[7:0]}};
        o_wstrb      = 4'b0001 << i_off;
        o_load_data  = w_unsigned ? {24'h0, w_lane[7:0]}
                                  : {{24{w_lane[7]}}, w_lane[7:0]};
      end
      SZ_H: begin
        o_wdata      = {2{i_store_data[15:0]}};
        o_wstrb      = 4'b0011 << {i_off[1], 1'b0};
        o_misaligned = i_off[0];
        o_load_data  = w_unsigned ? {16'h0, w_lane[15:0]}
                                  : {{16{w_lane[15]}}, w_lane[15:0]};
      end
      default: begin
        o_wdata      = i_store_data;
        o_wstrb      = 4'b1111;
        o_misaligned = |i_off;
        o_load_data  = w_lane;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-stage load/store unit.
// Runs one data-memory transaction per load/store over a valid/ready bus and
// stalls the upstream pipeline until it completes.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   load_mem, store_mem      : instruction class from EX/MEM
//   funct3_mem               : access width code
//   alu_data_mem             : effective byte address
//   rs2_data_mem             : store data
//   dmem_req/we/addr/wdata/wstrb : bus request fields (held through ACCESS)
//   dmem_ready, dmem_rdata   : bus handshake and read data
//   stall                    : freeze PC and pipeline up to EX/MEM
//   load_data                : extended load result (0 for store/error)
//   done, misaligned, bus_timeout : one-cycle completion pulses
module mem_access
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_mem,
  input  logic        store_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] alu_data_mem,
  input  logic [31:0] rs2_data_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        misaligned,
  output logic        bus_timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  // Last wait count that still keeps the request up; one more unanswered
  // cycle abandons the access, giving exactly MAX_WAIT request cycles.
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  lsu_state_t  r_state;
  lsu_state_t  w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_load_data;
  logic        r_misaligned;
  logic        r_timeout;

  logic        w_req_in;
  logic        w_is_load;
  logic        w_stall;
  logic        w_tmo_hit;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic        w_mis;
  logic [31:0] w_load;

  assign w_req_in  = load_mem | store_mem;
  // A load wins when both class bits are set.
  assign w_is_load = load_mem;

  // In IDLE the lane logic sees the incoming instruction; once the access is
  // launched it sees the latched copy so extraction matches the issued bus op.
  assign w_f3  = (r_state == IDLE) ? funct3_mem        : r_f3;
  assign w_off = (r_state == IDLE) ? alu_data_mem[1:0] : r_off;

  lsu_align u_align (
    .i_funct3     (w_f3),
    .i_off        (w_off),
    .i_store_data (rs2_data_mem),
    .i_rdata      (dmem_rdata),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_misaligned (w_mis),
    .o_load_data  (w_load)
  );

  assign w_tmo_hit = (r_state == ACCESS) && !dmem_ready && (r_cnt == LAST);

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_in) begin
          w_stall = 1'b1;
          w_next  = w_mis ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        w_stall = 1'b1;
        if (dmem_ready || w_tmo_hit) begin
          w_next = RESP;
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_f3         <= 3'b000;
      r_off        <= 2'b00;
      r_we         <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_wstrb      <= 4'h0;
      r_load_data  <= 32'h0;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_misaligned <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_in) begin
            if (w_mis) begin
              r_misaligned <= 1'b1;
              r_load_data  <= 32'h0;
            end else begin
              r_addr  <= {alu_data_mem[31:2], 2'b00};
              r_we    <= !w_is_load;
              r_wdata <= w_is_load ? 32'h0 : w_wdata;
              r_wstrb <= w_is_load ? 4'h0  : w_wstrb;
              r_f3    <= funct3_mem;
              r_off   <= alu_data_mem[1:0];
              r_cnt   <= '0;
            end
          end
        end
        ACCESS: begin
          if (dmem_ready) begin
            r_load_data <= r_we ? 32'h0 : w_load;
          end else if (w_tmo_hit) begin
            r_timeout   <= 1'b1;
            r_load_data <= 32'h0;
          end else if (r_cnt != {CW{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dmem_req    = (r_state == ACCESS);
  assign dmem_we     = r_we;
  assign dmem_addr   = r_addr;
  assign dmem_wdata  = r_wdata;
  assign dmem_wstrb  = r_wstrb;
  assign stall       = w_stall;
  assign load_data   = r_load_data;
  assign done        = (r_state == RESP);
  assign misaligned  = r_misaligned;
  assign bus_timeout = r_timeout;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic        load_mem;
  logic        store_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] alu_data_mem;
  logic [31:0] rs2_data_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        misaligned;
  logic        bus_timeout;

  int n_checks;
  int n_fail;

  mem_access #(.MAX_WAIT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_mem     (load_mem),
    .store_mem    (store_mem),
    .funct3_mem   (funct3_mem),
    .alu_data_mem (alu_data_mem),
    .rs2_data_mem (rs2_data_mem),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wstrb   (dmem_wstrb),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata),
    .stall        (stall),
    .load_data    (load_data),
    .done         (done),
    .misaligned   (misaligned),
    .bus_timeout  (bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Results of one transaction as seen on the outputs.
  int          a_stall, a_req;
  logic        a_done, a_we, a_mis, a_tmo;
  logic [31:0] a_addr, a_wdata, a_ld;
  logic [3:0]  a_wstrb;

  // Presents one instruction, answers the bus after 'delay' unanswered
  // ACCESS cycles (delay >= 64 means never), and records what happened up
  // to and including the done cycle. Returns #1 after the negedge of RESP.
  task automatic do_access(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int delay, input logic [31:0] rd);
    a_stall = 0; a_req = 0; a_done = 0; a_we = 0; a_mis = 0; a_tmo = 0;
    a_addr = 0; a_wdata = 0; a_ld = 0; a_wstrb = 0;
    @(negedge clk);
    load_mem = ld; store_mem = st; funct3_mem = f3;
    alu_data_mem = addr; rs2_data_mem = wd;
    dmem_ready = 1'b0; dmem_rdata = rd;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall) a_stall++;
      if (dmem_req) begin
        a_req++;
        if (a_req == 1) begin
          a_addr = dmem_addr; a_we = dmem_we;
          a_wdata = dmem_wdata; a_wstrb = dmem_wstrb;
        end
      end
      dmem_ready = dmem_req && (a_req > delay);
      if (done) begin
        a_done = 1'b1; a_ld = load_data; a_mis = misaligned; a_tmo = bus_timeout;
        break;
      end
      @(negedge clk);
    end
    load_mem = 1'b0; store_mem = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; load_mem = 0; store_mem = 0; funct3_mem = 0;
    alu_data_mem = 0; rs2_data_mem = 0; dmem_ready = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   {31'h0, dmem_req}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_done",  {31'h0, done}, 32'h0);
    chk("rst_flags", {30'h0, misaligned, bus_timeout}, 32'h0);
    chk("rst_ld",    load_data, 32'h0);
    chk("rst_addr",  dmem_addr, 32'h0);
    chk("rst_wstrb", {28'h0, dmem_wstrb}, 32'h0);
    rst = 1'b0;

    // SW 0x100, ready in the first ACCESS cycle
    do_access(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    chk("sw_done",  {31'h0, a_done}, 32'h1);
    chk("sw_addr",  a_addr, 32'h100);
    chk("sw_we",    {31'h0, a_we}, 32'h1);
    chk("sw_wstrb", {28'h0, a_wstrb}, 32'hF);
    chk("sw_wdata", a_wdata, 32'hDEADBEEF);
    chk("sw_stall", a_stall, 2);
    chk("sw_req",   a_req, 1);
    chk("sw_ld",    a_ld, 32'h0);

    // LB / LBU at 0x103 read 0x80FF1234 -> top byte 0x80
    do_access(1'b1, 1'b0, F3_B, 32'h103, 32'h0, 0, 32'h80FF1234);
    chk("lb_addr", a_addr, 32'h100);
    chk("lb_we",   {31'h0, a_we}, 32'h0);
    chk("lb_ld",   a_ld, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 0, 32'h80FF1234);
    chk("lbu_ld",  a_ld, 32'h00000080);

    // SH at 0x202: upper half lanes
    do_access(1'b0, 1'b1, F3_H, 32'h202, 32'h0000ABCD, 0, 32'h0);
    chk("sh_addr",  a_addr, 32'h200);
    chk("sh_wstrb", {28'h0, a_wstrb}, 32'hC);
    chk("sh_wdata", a_wdata, 32'hABCDABCD);

    // SB at 0x001: lane 1, byte replicated
    do_access(1'b0, 1'b1, F3_B, 32'h001, 32'h123456A5, 0, 32'h0);
    chk("sb_wstrb", {28'h0, a_wstrb}, 32'h2);
    chk("sb_wdata", a_wdata, 32'hA5A5A5A5);

    // LHU at 0x202 read 0xABCD0000
    do_access(1'b1, 1'b0, F3_HU, 32'h202, 32'h0, 0, 32'hABCD0000);
    chk("lhu_ld", a_ld, 32'h0000ABCD);

    // LH at 0x106 with 3 wait cycles: stall 2+3, request 4 cycles
    do_access(1'b1, 1'b0, F3_H, 32'h106, 32'h0, 3, 32'h9ABC5678);
    chk("lh_ld",    a_ld, 32'hFFFF9ABC);
    chk("lh_stall", a_stall, 5);
    chk("lh_req",   a_req, 4);

    // LW never answered: 15 request cycles then timeout
    do_access(1'b1, 1'b0, F3_W, 32'h400, 32'h0, 64, 32'hFFFFFFFF);
    chk("tmo_done",  {31'h0, a_done}, 32'h1);
    chk("tmo_req",   a_req, 15);
    chk("tmo_stall", a_stall, 16);
    chk("tmo_flag",  {31'h0, a_tmo}, 32'h1);
    chk("tmo_mis",   {31'h0, a_mis}, 32'h0);
    chk("tmo_ld",    a_ld, 32'h0);
    @(negedge clk); #1;
    chk("tmo_pulse", {30'h0, bus_timeout, done}, 32'h0);

    // LW at 0x101 is misaligned: no bus traffic
    do_access(1'b1, 1'b0, F3_W, 32'h101, 32'h0, 0, 32'h0);
    chk("mis_done",  {31'h0, a_done}, 32'h1);
    chk("mis_flag",  {31'h0, a_mis}, 32'h1);
    chk("mis_req",   a_req, 0);
    chk("mis_stall", a_stall, 1);
    chk("mis_ld",    a_ld, 32'h0);
    @(negedge clk); #1;
    chk("mis_pulse", {30'h0, misaligned, done}, 32'h0);

    // SH at odd address is misaligned as well
    do_access(1'b0, 1'b1, F3_H, 32'h203, 32'h1111, 0, 32'h0);
    chk("shm_flag", {31'h0, a_mis}, 32'h1);
    chk("shm_req",  a_req, 0);

    // Load and store both set: treated as a load
    do_access(1'b1, 1'b1, F3_W, 32'h010, 32'h55555555, 0, 32'hCAFEF00D);
    chk("both_we", {31'h0, a_we}, 32'h0);
    chk("both_ld", a_ld, 32'hCAFEF00D);

    // Undefined funct3 011 behaves as word
    do_access(1'b0, 1'b1, 3'b011, 32'h020, 32'h11223344, 0, 32'h0);
    chk("f3u_wstrb", {28'h0, a_wstrb}, 32'hF);
    chk("f3u_wdata", a_wdata, 32'h11223344);

    // Reset in the 3rd ACCESS cycle of a stalled load
    @(negedge clk);
    load_mem = 1'b1; funct3_mem = F3_W; alu_data_mem = 32'h300; dmem_ready = 1'b0;
    begin
      int acc;
      acc = 0;
      for (int c = 0; c < 10 && acc < 3; c++) begin
        @(negedge clk); #1;
        if (dmem_req) acc++;
      end
      chk("rma_reach", acc, 3);
    end
    rst = 1'b1; load_mem = 1'b0;
    @(negedge clk);
    rst = 1'b0; #1;
    chk("rma_req",   {31'h0, dmem_req}, 32'h0);
    chk("rma_stall", {31'h0, stall}, 32'h0);
    chk("rma_state", {30'h0, dut.r_state}, {30'h0, IDLE});
    begin
      int nd;
      nd = 0;
      for (int c = 0; c < 5; c++) begin
        if (done) nd++;
        @(negedge clk); #1;
      end
      chk("rma_nodone", nd, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
